seq_chunk_adder: RTL and testbench

//  Parametrised multi-cycle adder: WIDTH-bit A+B+Cin computed CHUNK bits per clock with a registered

---
 rtl/seq_chunk_adder_pkg.sv | 22 ++
 rtl/seq_chunk_adder_rca_slice.sv | 27 ++
 rtl/seq_chunk_adder.sv | 145 ++++++++++++++
 tb/tb_seq_chunk_adder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked sequential adder: FSM state encoding
// and a constant-function log2 used to size the slice index.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2 with a floor of 1 so a single-slice build still has a
    // one-bit index register.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_rca_slice.sv
// Combinational CHUNK-bit ripple carry adder: one full-adder per bit.
// c_msb is the carry entering the top bit, used for signed overflow.
module rca_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] cc;

    assign cc[0] = ci;

    // Full-adder chain, carry ripples from bit 0 upwards.
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]    = a[i] ^ b[i] ^ cc[i];
        assign cc[i+1] = (a[i] & b[i]) | (cc[i] & (a[i] ^ b[i]));
    end

    assign co    = cc[CHUNK];
    assign c_msb = cc[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit A+B+Cin computed CHUNK bits per clock with
// a registered carry between slices. One rca_slice instance is shared and
// fed the current slice via the idx mux.
// Optional feature macro: SEQ_ADDER_OVF_EN adds the OVF (signed overflow)
// output and its register.
//
// Handshake: ready=1 in IDLE and DONE; a request is accepted on any rising
// edge where start=1 and ready=1 (operands and Cin sampled on that edge).
// start while busy is ignored. done is a one-cycle pulse; S/Cout/OVF stay
// valid from done until the next accepted start.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
`ifdef SEQ_ADDER_OVF_EN
    output logic             OVF,
`endif
    output logic [1:0]       dbg_state
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int IDXW   = clog2(NSLICE);

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;
    logic [CHUNK-1:0]  sl_a;
    logic [CHUNK-1:0]  sl_b;
    logic [CHUNK-1:0]  sl_s;
    logic              sl_co;
    logic              accept;
    logic              last;

    assign accept    = start && (state_q != ST_RUN);
    assign last      = (state_q == ST_RUN) && (idx_q == IDXW'(NSLICE - 1));
    assign ready     = (state_q != ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

    // Select the operand slice addressed by idx.
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (idx_q == IDXW'(k)) begin
                sl_a = a_q[k*CHUNK +: CHUNK];
                sl_b = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

`ifdef SEQ_ADDER_OVF_EN
    logic sl_c_msb;

    rca_slice #(.CHUNK(CHUNK)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .ci    (carry_q),
        .s     (sl_s),
        .co    (sl_co),
        .c_msb (sl_c_msb)
    );
`else
    rca_slice #(.CHUNK(CHUNK)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .ci    (carry_q),
        .s     (sl_s),
        .co    (sl_co),
        .c_msb ()
    );
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: DONE can go straight back to RUN on a held/new start.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, per-slice accumulation and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            S       <= '0;
            Cout    <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
            OVF     <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            idx_q   <= '0;
            S       <= '0;
            Cout    <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
            OVF     <= 1'b0;
`endif
        end else if (state_q == ST_RUN) begin
            for (int k = 0; k < NSLICE; k++) begin
                if (idx_q == IDXW'(k)) S[k*CHUNK +: CHUNK] <= sl_s;
            end
            carry_q <= sl_co;
            idx_q   <= idx_q + 1'b1;
            if (last) begin
                Cout <= sl_co;
`ifdef SEQ_ADDER_OVF_EN
                OVF  <= sl_c_msb ^ sl_co;
`endif
            end
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three instances (CHUNK = 4, 16, 1) share one
// stimulus stream; a reference model predicts acceptance, latency and the
// A+B+Cin result, and a monitor checks each done pulse against the queue.
module tb_seq_chunk_adder;

    localparam int W  = 16;
    localparam int NI = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic         ready_v [NI];
    logic         busy_v  [NI];
    logic         done_v  [NI];
    logic         cout_v  [NI];
    logic         ovf_v   [NI];
    logic [W-1:0] s_v     [NI];
    logic [1:0]   st_v    [NI];

    int           nsl     [NI];
    int           free_at [NI];
    logic [W+1:0] exp_q   [NI][$];
    int           due_q   [NI][$];

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int C = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
        seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .A         (a),
            .B         (b),
            .Cin       (cin),
            .ready     (ready_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g]),
            .S         (s_v[g]),
            .Cout      (cout_v[g]),
`ifdef SEQ_ADDER_OVF_EN
            .OVF       (ovf_v[g]),
`endif
            .dbg_state (st_v[g])
        );
`ifndef SEQ_ADDER_OVF_EN
        assign ovf_v[g] = 1'b0;
`endif
    end

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [inst%0d] got %h expected %h at cycle %0d", nm, g, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, result {sum, carry, signed overflow}.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint       t;
        int           sv;
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
        t   = longint'(x) + longint'(y) + longint'(c);
        sum = t[W-1:0];
        co  = (t >= 65536);
        sv  = int'($signed(x)) + int'($signed(y)) + int'(c);
        ov  = (sv > 32767) || (sv < -32768);
        return {sum, co, ov};
    endfunction

    // Driver: present inputs for one edge and predict which instances accept.
    task automatic step(input bit st, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        @(negedge clk);
        #1;
        start = st;
        a     = ta;
        b     = tb;
        cin   = tc;
        if (st) begin
            for (int g = 0; g < NI; g++) begin
                if (cyc + 1 >= free_at[g]) begin
                    exp_q[g].push_back(ref_add(ta, tb, tc));
                    due_q[g].push_back(cyc + 1 + nsl[g]);
                    free_at[g] = cyc + 2 + nsl[g];
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, a, b, cin);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b0;
        for (int g = 0; g < NI; g++) begin
            exp_q[g].delete();
            due_q[g].delete();
            free_at[g] = 0;
        end
        repeat (n) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            chk("rst_S", g, 32'(s_v[g]), 32'h0);
            chk("rst_Cout", g, 32'(cout_v[g]), 32'h0);
            chk("rst_done", g, 32'(done_v[g]), 32'h0);
            chk("rst_busy", g, 32'(busy_v[g]), 32'h0);
            chk("rst_ready", g, 32'(ready_v[g]), 32'h1);
`ifdef SEQ_ADDER_OVF_EN
            chk("rst_OVF", g, 32'(ovf_v[g]), 32'h0);
`endif
        end
        rst = 1'b0;
    endtask

    task automatic drain();
        int  k;
        bit  pend;
        k    = 0;
        pend = 1'b1;
        while (pend && k < 100) begin
            @(negedge clk);
            #2;
            k++;
            pend = 1'b0;
            for (int g = 0; g < NI; g++) if (exp_q[g].size() != 0) pend = 1'b1;
        end
        if (pend) begin
            for (int g = 0; g < NI; g++) chk("drain_timeout", g, 32'(exp_q[g].size()), 32'h0);
        end
    endtask

    // Monitor: on every done pulse pop and compare; flag late or missing pulses.
    task automatic monitor();
        logic [W+1:0] e;
        int           d;
        forever begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                if (done_v[g] === 1'b1) begin
                    if (exp_q[g].size() == 0) begin
                        chk("unexpected_done", g, 32'(done_v[g]), 32'h0);
                    end else begin
                        e = exp_q[g].pop_front();
                        d = due_q[g].pop_front();
                        chk("latency", g, 32'(cyc), 32'(d));
                        chk("S", g, 32'(s_v[g]), 32'(e[W+1:2]));
                        chk("Cout", g, 32'(cout_v[g]), 32'(e[1]));
`ifdef SEQ_ADDER_OVF_EN
                        chk("OVF", g, 32'(ovf_v[g]), 32'(e[0]));
`endif
                        chk("ready_in_done", g, 32'(ready_v[g]), 32'h1);
                        chk("busy_in_done", g, 32'(busy_v[g]), 32'h0);
                    end
                end else if (due_q[g].size() != 0 && due_q[g][0] <= cyc) begin
                    chk("done_missing", g, 32'(done_v[g]), 32'h1);
                    void'(exp_q[g].pop_front());
                    void'(due_q[g].pop_front());
                end
            end
        end
    endtask

    initial begin
        nsl[0] = W / 4;
        nsl[1] = W / 16;
        nsl[2] = W / 1;
        for (int g = 0; g < NI; g++) free_at[g] = 0;

        fork
            monitor();
        join_none

        // Reset state.
        do_reset(2);

        // Simple add, carry through every slice, signed overflow corners.
        step(1'b1, 16'h0001, 16'h0001, 1'b0); idle(1); drain();
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0); idle(1); drain();
        step(1'b1, 16'h7FFF, 16'h0000, 1'b1); idle(1); drain();
        step(1'b1, 16'h8000, 16'h8000, 1'b0); idle(1); drain();
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1); idle(1); drain();

        // Start while busy is ignored; start held through DONE is accepted.
        step(1'b1, 16'd5, 16'd4, 1'b1);
        idle(2);
        #1;
        chk("busy_mid", 0, 32'(busy_v[0]), 32'h1);
        chk("ready_mid", 0, 32'(ready_v[0]), 32'h0);
        step(1'b1, 16'd10, 16'd4, 1'b0);
        step(1'b1, 16'd3, 16'd0, 1'b1);
        step(1'b1, 16'd3, 16'd0, 1'b1);
        idle(1);
        drain();

        // Reset mid-operation aborts; the same op then completes normally.
        step(1'b1, 16'h1234, 16'h1111, 1'b0);
        idle(2);
        do_reset(1);
        idle(2);
        step(1'b1, 16'h1234, 16'h1111, 1'b0); idle(1); drain();

        // Random traffic: start pulses land in every state.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        idle(1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
